store_buffer: RTL and testbench

Write-queue stage directly upstream of `processor`'s data-memory store port. Accepts store requests (address/data) from the issuing logic over a valid/ready handshake, buffers up to `DEPTH` of them in order, and replays them one per cycle onto the processor's `S` / `data_addr_in` / `data_in` inputs, holding off while the processor signals `E`. Optional youngest-match forwarding lets a load check for a pending store before it reaches memory.

---
 rtl/store_buffer.sv | 116 +++++++++++
 tb/tb_store_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order store queue feeding the processor store port (S / data_addr_in / data_in).
// Define STORE_BUF_FWD_EN to enable youngest-match load forwarding (ld_hit / ld_data).
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     E,
  input  logic                     flush,
  output logic                     S,
  output logic [AW-1:0]            data_addr_in,
  output logic [DW-1:0]            data_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     align_err,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          misaligned;
  logic          push;
  logic          pop;

  assign in_ready   = (count != CW'(DEPTH)) && !flush;
  assign accept     = in_valid && in_ready;
  assign misaligned = (in_addr[1:0] != 2'b00);
  assign push       = accept && !misaligned;
  assign pop        = (count != '0) && !E && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      S            <= 1'b0;
      data_addr_in <= '0;
      data_in      <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      S      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        data_addr_in <= addr_mem[rd_ptr];
        data_in      <= data_mem[rd_ptr];
        S            <= 1'b1;
      end else begin
        S <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else if (accept && misaligned) begin
      align_err <= 1'b1;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_mem[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[idx];
      end
    end
  end
`else
  logic unused_ld;

  assign unused_ld = ^ld_addr;
  assign ld_hit    = 1'b0;
  assign ld_data   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer with a queue-based reference model
// and a decoupled scoreboard monitor that checks every store strobe and status output.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        E;
  logic        flush;
  logic        S;
  logic [31:0] data_addr_in;
  logic [31:0] data_in;
  logic [2:0]  count;
  logic        align_err;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .E(E), .flush(flush), .S(S),
    .data_addr_in(data_addr_in), .data_in(data_in), .count(count),
    .align_err(align_err), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t  mq[$];     // model contents of the buffer
  st_t  exp_q[$];  // stores the model says were issued at the last edge
  logic model_align;
  int   tests;
  int   fails;
  logic done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (!reset) begin
      mq.delete();
      exp_q.delete();
      model_align = 1'b0;
      return;
    end
    if (flush) begin
      mq.delete();
      return;
    end
    acc = in_valid && (mq.size() < DEPTH);
    if (mq.size() != 0 && !E) exp_q.push_back(mq.pop_front());
    if (acc) begin
      if (in_addr[1:0] != 2'b00) model_align = 1'b1;
      else mq.push_back('{a: in_addr, d: in_data});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic e, input logic f, input logic [31:0] la);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    E        = e;
    flush    = f;
    ld_addr  = la;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, e, 1'b0, 32'h0);
  endtask

  // Monitor: consumes expected issues whenever S is seen and checks status outputs.
  initial begin
    st_t  x;
    logic exp_hit;
    logic [31:0] exp_ld;
    while (done !== 1'b1) begin
      @(negedge clk);
      if (S === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_S", 64'(S), 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("store_addr", 64'(data_addr_in), 64'(x.a));
          chk("store_data", 64'(data_in), 64'(x.d));
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("missing_S", 64'(S), 64'd1);
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'((mq.size() != DEPTH) && !flush));
      chk("align_err", 64'(align_err), 64'(model_align));
      exp_hit = 1'b0;
      exp_ld  = 32'h0;
`ifdef STORE_BUF_FWD_EN
      foreach (mq[i]) begin
        if (mq[i].a == ld_addr) begin
          exp_hit = 1'b1;
          exp_ld  = mq[i].d;
        end
      end
`endif
      chk("ld_hit", 64'(ld_hit), 64'(exp_hit));
      chk("ld_data", 64'(ld_data), 64'(exp_ld));
    end
  end

  initial begin
    done = 1'b0;
    tests = 0;
    fails = 0;
    model_align = 1'b0;
    reset = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0; E = 1'b0; flush = 1'b0; ld_addr = '0;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1 reset = 1'b1;

    // single store, two-edge latency
    drive(1'b1, 32'h04, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0);
    idle(4, 1'b0);

    // stalled fill beyond depth, then drain in order
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h100 + 32'(4 * i), 32'hD000 + 32'(i), 1'b1, 1'b0, 32'h0);
    chk("full_count", 64'(count), 64'(DEPTH));
    idle(7, 1'b0);

    // misaligned drop, then aligned store
    drive(1'b1, 32'h06, 32'h66, 1'b0, 1'b0, 32'h0);
    chk("align_sticky", 64'(align_err), 64'd1);
    drive(1'b1, 32'h08, 32'h88, 1'b0, 1'b0, 32'h0);
    idle(4, 1'b0);

    // flush beats a concurrent push
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + 32'(4 * i), 32'hF0 + 32'(i), 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h300, 32'h12345678, 1'b1, 1'b1, 32'h0);
    chk("flush_count", 64'(count), 64'd0);
    idle(4, 1'b0);

    // forwarding lookup with youngest match
    drive(1'b1, 32'h10, 32'h11, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h20, 32'h22, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h10, 32'h33, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10);
`ifdef STORE_BUF_FWD_EN
    chk("fwd_hit", 64'(ld_hit), 64'd1);
    chk("fwd_data", 64'(ld_data), 64'h33);
`else
    chk("fwd_off_hit", 64'(ld_hit), 64'd0);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30);
    chk("fwd_miss", 64'(ld_hit), 64'd0);

    // asynchronous reset mid-drain
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_S", 64'(S), 64'd1);
    #2 reset = 1'b0;
    mq.delete();
    exp_q.delete();
    model_align = 1'b0;
    #1;
    chk("rst_S", 64'(S), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    model_step();
    #1 reset = 1'b1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = 32'h10 * 32'($urandom_range(1, 4));
      if ($urandom_range(0, 39) == 0) a = a | 32'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 3) != 0), a, $urandom,
            1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 29) == 0),
            32'h10 * 32'($urandom_range(1, 5)));
    end
    idle(8, 1'b0);
    @(negedge clk);
    chk("final_drained", 64'(exp_q.size() + mq.size()), 64'd0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
